// File: rtl/spi_ram_arbiter.sv
// Decodes the SPI command stream into RAM accesses and arbitrates the single RAM port with a host port.
// Optional macro ARB_SPI_PRIORITY_EN: SPI always wins ties (default build is round-robin).
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [ADDR_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [ADDR_SIZE-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [ADDR_SIZE-1:0] ram_wdata,
  input  logic [ADDR_SIZE-1:0] ram_rdata,
  output logic                 spi_ovf
);

  typedef enum logic [1:0] {IDLE, ACC_SPI, ACC_HOST} state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_pend_valid;
  logic                 r_pend_we;
  logic [ADDR_SIZE-1:0] r_pend_addr;
  logic [ADDR_SIZE-1:0] r_pend_wdata;
  logic                 r_last_host;
  logic                 r_rd_pend;
  logic                 r_rd_spi;

  logic [1:0]           w_opcode;
  logic [ADDR_SIZE-1:0] w_payload;
  logic                 w_cmd_acc;
  logic                 w_spi_cand;
  logic                 w_host_cand;
  logic                 w_pend_free;
  logic                 w_spi_wins;
  logic                 w_ram_we_next;
  logic [ADDR_SIZE-1:0] w_ram_addr_next;
  logic [ADDR_SIZE-1:0] w_ram_wdata_next;

  function automatic logic [ADDR_SIZE-1:0] wrap_addr(input logic [ADDR_SIZE-1:0] a);
    return ADDR_SIZE'(32'(a) % MEM_DEPTH);
  endfunction

  assign w_opcode    = rx_data[ADDR_SIZE+1:ADDR_SIZE];
  assign w_payload   = rx_data[ADDR_SIZE-1:0];
  assign w_cmd_acc   = rx_valid && w_opcode[0];
  // The buffer being served this cycle is no longer a candidate and may be refilled.
  assign w_spi_cand  = r_pend_valid && (r_state != ACC_SPI);
  assign w_host_cand = host_req && !host_gnt;
  assign w_pend_free = !r_pend_valid || (r_state == ACC_SPI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = IDLE;
    w_spi_wins       = 1'b0;
    w_ram_we_next    = 1'b0;
    w_ram_addr_next  = '0;
    w_ram_wdata_next = '0;
`ifdef ARB_SPI_PRIORITY_EN
    w_spi_wins = w_spi_cand;
`else
    w_spi_wins = w_spi_cand && (!w_host_cand || r_last_host);
`endif
    if (w_spi_wins) begin
      w_state_next = ACC_SPI;
    end else if (w_host_cand) begin
      w_state_next = ACC_HOST;
    end
    case (w_state_next)
      ACC_SPI: begin
        w_ram_we_next    = r_pend_we;
        w_ram_addr_next  = wrap_addr(r_pend_addr);
        w_ram_wdata_next = r_pend_we ? r_pend_wdata : '0;
      end
      ACC_HOST: begin
        w_ram_we_next    = host_we;
        w_ram_addr_next  = wrap_addr(host_addr);
        w_ram_wdata_next = host_we ? host_wdata : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      host_gnt     <= 1'b0;
      r_last_host  <= 1'b1;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      spi_ovf      <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_spi     <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
    end else begin
      ram_en    <= (w_state_next != IDLE);
      ram_we    <= w_ram_we_next;
      ram_addr  <= w_ram_addr_next;
      ram_wdata <= w_ram_wdata_next;
      host_gnt  <= (w_state_next == ACC_HOST);
      if (w_state_next == ACC_SPI) begin
        r_last_host <= 1'b0;
      end else if (w_state_next == ACC_HOST) begin
        r_last_host <= 1'b1;
      end

      if (rx_valid && !w_opcode[0]) begin
        if (w_opcode[1]) begin
          r_rd_addr <= w_payload;
        end else begin
          r_wr_addr <= w_payload;
        end
      end

      // Address is frozen into the buffer at decode time.
      if (w_cmd_acc && w_pend_free) begin
        r_pend_valid <= 1'b1;
        r_pend_we    <= !w_opcode[1];
        r_pend_addr  <= w_opcode[1] ? r_rd_addr : r_wr_addr;
        r_pend_wdata <= w_payload;
      end else if (r_state == ACC_SPI) begin
        r_pend_valid <= 1'b0;
      end
      if (w_cmd_acc && !w_pend_free) begin
        spi_ovf <= 1'b1;
      end

      r_rd_pend   <= ram_en && !ram_we;
      r_rd_spi    <= (r_state == ACC_SPI);
      tx_valid    <= r_rd_pend && r_rd_spi;
      host_rvalid <= r_rd_pend && !r_rd_spi;
      if (r_rd_pend && r_rd_spi) begin
        tx_data <= ram_rdata;
      end
      if (r_rd_pend && !r_rd_spi) begin
        host_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed plus randomized bench for spi_ram_arbiter with an external RAM and a memory-level reference.
module tb_spi_ram_arbiter;
  localparam int AW = 8;
  localparam logic [1:0] OP_WA = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RA = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW+1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] tx_data;
  logic          tx_valid;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [AW-1:0] host_wdata = '0;
  logic          host_gnt;
  logic [AW-1:0] host_rdata;
  logic          host_rvalid;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [AW-1:0] ram_wdata;
  logic [AW-1:0] ram_rdata;
  logic          spi_ovf;

  spi_ram_arbiter #(.ADDR_SIZE(AW), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  // External single-port RAM with registered read.
  logic [AW-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  logic [AW-1:0] ref_mem [256];
  bit  last_host;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi(input logic [1:0] op, input logic [AW-1:0] p);
    rx_data  = {op, p};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    last_host = 1'b1;
  endtask

  task automatic count_tx(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx_valid) cnt++;
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
            ram_en, ram_we, ram_addr, ram_wdata, spi_ovf};
  endfunction

  initial begin
    int cnt;
    logic [AW-1:0] a, b, d;
    int kind;
    bit spi_first;

    for (int i = 0; i < 256; i++) begin
      d = AW'($urandom);
      ram[i] = d;
      ref_mem[i] = d;
    end

    // Reset state
    tick();
    chk("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    tick();
    last_host = 1'b1;

    // Reset in the middle of an SPI read
    spi(OP_RA, 8'h12);
    spi(OP_RD, 8'h00);
    tick();
    chk("midrd_acc", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'h12});
    #2 rst = 1'b1;
    #1 chk("midrd_outs", all_outs(), 64'd0);
    tick();
    rst = 1'b0;
    count_tx(6, cnt);
    chk("midrd_no_tx", cnt, 0);
    chk("midrd_ovf", spi_ovf, 1'b0);
    last_host = 1'b1;

    // SPI write
    spi(OP_WA, 8'h12);
    spi(OP_WR, 8'h5A);
    tick();
    chk("spiwr_acc", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 8'h12, 8'h5A});
    ref_mem[8'h12] = 8'h5A;
    tick();
    chk("spiwr_single", ram_en, 1'b0);

    // SPI read
    spi(OP_RA, 8'h12);
    spi(OP_RD, 8'h00);
    tick();
    chk("spird_acc", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'h12});
    tick();
    chk("spird_early", {ram_en, tx_valid}, 2'b00);
    tick();
    chk("spird_tx", {tx_valid, tx_data}, {1'b1, ref_mem[8'h12]});
    tick();
    chk("spird_hold", {tx_valid, tx_data}, {1'b0, ref_mem[8'h12]});

    // Contention right after reset: SPI wins the first tie
    do_reset();
    spi(OP_WA, 8'h12);
    spi(OP_WR, 8'hA5);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    tick();
    chk("cont_spi_first", {ram_en, ram_we, host_gnt, ram_addr, ram_wdata}, {3'b110, 8'h12, 8'hA5});
    ref_mem[8'h12] = 8'hA5;
    tick();
    chk("cont_host_next", {host_gnt, ram_en, ram_we, ram_addr}, {3'b110, 8'h30});
    host_req = 1'b0;
    tick();
    chk("cont_gnt_pulse", host_gnt, 1'b0);
    tick();
    chk("cont_host_rd", {host_rvalid, host_rdata}, {1'b1, ref_mem[8'h30]});

    // After an SPI grant, the host wins the next tie
    spi(OP_RA, 8'h12);
    spi(OP_RD, 8'h00);
    tick();
    chk("alt_spi_a", {ram_en, host_gnt, ram_addr}, {2'b10, 8'h12});
    spi(OP_RD, 8'h00);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h55;
    tick();
    chk("alt_host_wins", {host_gnt, ram_addr, tx_valid, tx_data}, {1'b1, 8'h55, 1'b1, ref_mem[8'h12]});
    host_req = 1'b0;
    tick();
    chk("alt_spi_b", {ram_en, host_gnt, ram_addr}, {2'b10, 8'h12});
    tick();
    chk("alt_host_rd", {host_rvalid, host_rdata}, {1'b1, ref_mem[8'h55]});
    tick();
    chk("alt_spi_rd", {tx_valid, tx_data}, {1'b1, ref_mem[8'h12]});
    tick();
    last_host = 1'b0;

    // Host write then read to the same address
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h7F; host_wdata = 8'hC3;
    tick();
    chk("hb2b_wr", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata}, {3'b111, 8'h7F, 8'hC3});
    ref_mem[8'h7F] = 8'hC3;
    host_we = 1'b0;
    tick();
    chk("hb2b_gap", {host_gnt, ram_en}, 2'b00);
    tick();
    chk("hb2b_rd", {host_gnt, ram_en, ram_we, ram_addr}, {3'b110, 8'h7F});
    host_req = 1'b0;
    tick();
    tick();
    chk("hb2b_data", {host_rvalid, host_rdata}, {1'b1, 8'hC3});
    last_host = 1'b1;

    // Randomized traffic against the memory-level reference
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      a = AW'($urandom);
      b = AW'($urandom);
      d = AW'($urandom);
      case (kind)
        0: begin
          spi(OP_WA, a);
          spi(OP_WR, d);
          tick();
          chk("rnd_spi_wr", {ram_en, ram_we, host_gnt, ram_addr, ram_wdata}, {3'b110, a, d});
          ref_mem[a] = d;
          last_host = 1'b0;
          tick();
        end
        1: begin
          spi(OP_RA, a);
          spi(OP_RD, d);
          tick();
          chk("rnd_spi_acc", {ram_en, ram_we, ram_addr}, {2'b10, a});
          tick();
          tick();
          chk("rnd_spi_rd", {tx_valid, tx_data}, {1'b1, ref_mem[a]});
          last_host = 1'b0;
          tick();
        end
        2: begin
          host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
          tick();
          chk("rnd_host_wr", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata}, {3'b111, a, d});
          host_req = 1'b0;
          ref_mem[a] = d;
          last_host = 1'b1;
          tick();
        end
        3: begin
          host_req = 1'b1; host_we = 1'b0; host_addr = a;
          tick();
          chk("rnd_host_acc", {host_gnt, ram_en, ram_we, ram_addr}, {3'b110, a});
          host_req = 1'b0;
          tick();
          tick();
          chk("rnd_host_rd", {host_rvalid, host_rdata}, {1'b1, ref_mem[a]});
          last_host = 1'b1;
          tick();
        end
        default: begin
          // Simultaneous SPI read (addr a) and host read (addr b)
          spi_first = last_host;
          spi(OP_RA, a);
          spi(OP_RD, d);
          host_req = 1'b1; host_we = 1'b0; host_addr = b;
          tick();
          if (spi_first) begin
            chk("rnd_tie_spi", {ram_en, host_gnt, ram_addr}, {2'b10, a});
            tick();
            chk("rnd_tie_host2", {ram_en, host_gnt, ram_addr}, {2'b11, b});
            host_req = 1'b0;
            tick();
            chk("rnd_tie_tx", {tx_valid, tx_data}, {1'b1, ref_mem[a]});
            tick();
            chk("rnd_tie_hrd", {host_rvalid, host_rdata}, {1'b1, ref_mem[b]});
            last_host = 1'b1;
          end else begin
            chk("rnd_tie_host", {ram_en, host_gnt, ram_addr}, {2'b11, b});
            host_req = 1'b0;
            tick();
            chk("rnd_tie_spi2", {ram_en, host_gnt, ram_addr}, {2'b10, a});
            tick();
            chk("rnd_tie_hrd", {host_rvalid, host_rdata}, {1'b1, ref_mem[b]});
            tick();
            chk("rnd_tie_tx", {tx_valid, tx_data}, {1'b1, ref_mem[a]});
            last_host = 1'b0;
          end
          tick();
        end
      endcase
    end
    chk("rnd_no_ovf", spi_ovf, 1'b0);

    // Overflow: host held, two SPI reads on consecutive edges
    spi(OP_RA, 8'h40);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h41;
    spi(OP_RD, 8'h00);
    chk("ovf_host_gnt", host_gnt, 1'b1);
    spi(OP_RD, 8'h00);
    chk("ovf_spi_acc", {spi_ovf, ram_en, host_gnt, ram_addr}, {3'b110, 8'h40});
    count_tx(6, cnt);
    host_req = 1'b0;
    chk("ovf_one_served", cnt, 1);
    tick();
    tick();
    chk("ovf_sticky", spi_ovf, 1'b1);
    do_reset();
    chk("ovf_cleared", spi_ovf, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
